// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences the shared data memory between the CPU (port 0) and the UART loader (port 1).
// Optional `MEM_ARB_PERF_EN adds the saturating cpu_stall_cnt / ld_wait_cnt performance counters.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              ld_lock,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       cpu_stall_cnt,
  output logic [31:0]       ld_wait_cnt
`endif
);

  localparam int CW = 2;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  state_t            state, state_nxt;
  txn_t              txn;
  logic              owner, last_owner;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] cpu_rdata_q, ld_rdata_q;
  logic              cpu_elig, ld_elig, pick_ld, rsp;

  assign cpu_elig = cpu_req & ~ld_lock;
  assign ld_elig  = ld_req;
  // Loader wins only when it is the sole eligible port or the CPU had the last grant.
  assign pick_ld  = ld_elig & (~cpu_elig | (last_owner == OWN_CPU));
  assign rsp      = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_elig || ld_elig) state_nxt = CMD;
      CMD:     state_nxt = txn.we ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= OWN_CPU;
      last_owner  <= OWN_LD;
      txn         <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_elig || ld_elig) begin
          owner     <= pick_ld;
          txn.we    <= pick_ld ? ld_we    : cpu_we;
          txn.addr  <= pick_ld ? ld_addr  : cpu_addr;
          txn.wdata <= pick_ld ? ld_wdata : cpu_wdata;
        end
        CMD: begin
          last_owner <= owner;
          cnt        <= CW'(RD_LATENCY - 1);
        end
        WAIT: begin
          if (cnt != '0)             cnt         <= cnt - CW'(1);
          else if (owner == OWN_LD)  ld_rdata_q  <= m_rdata;
          else                       cpu_rdata_q <= m_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only (plus the requester's own req for stall), so no
  // glitches are introduced by the arbiter itself.
  always_comb begin
    m_write    = (state == CMD) &  txn.we;
    m_read     = (state == CMD) & ~txn.we;
    m_addr     = txn.addr;
    m_wdata    = txn.wdata;
    cpu_gnt    = (state == CMD) & (owner == OWN_CPU);
    ld_gnt     = (state == CMD) & (owner == OWN_LD);
    cpu_rvalid = rsp & (owner == OWN_CPU);
    ld_rvalid  = rsp & (owner == OWN_LD);
    cpu_rdata  = cpu_rvalid ? m_rdata : cpu_rdata_q;
    ld_rdata   = ld_rvalid  ? m_rdata : ld_rdata_q;
    cpu_stall  = cpu_req & ~(cpu_gnt & txn.we) & ~cpu_rvalid;
  end

`ifdef MEM_ARB_PERF_EN
  logic ld_pend;
  assign ld_pend = ld_req & ~(ld_gnt & txn.we) & ~ld_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_stall_cnt <= '0;
      ld_wait_cnt   <= '0;
    end else begin
      if (cpu_stall && cpu_stall_cnt != '1) cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      if (ld_pend   && ld_wait_cnt   != '1) ld_wait_cnt   <= ld_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
